bldc_hall_model: RTL and testbench
==================================

BLDC_HALL_MODEL -- requirements
Module: bldc_hall_model

Interface
REQ-001 Parameter: COMM_THRESH, 20'h40000, position-accumulator count per commutation step; SHALL be >= 20'h10000.
REQ-002 Parameter: STALL_LIMIT, 10'd1000, consecutive zero-speed PWM_synch strobes before stall is flagged.
REQ-003 Port: clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: selGrn, selYlw, selBlu  input  2 each  phase drive code: 00 HIGHZ, 01 REVERSE, 10 FORWARD, 11 REGEN.
REQ-006 Port: duty  input  11  drive magnitude.
REQ-007 Port: PWM_synch  input  1  single-cycle speed-update strobe.
REQ-008 Port: hallGrn, hallYlw, hallBlu  output  1 each  emulated hall sensor outputs, registered.
REQ-009 Port: speed  output  16  rotor speed, unsigned, registered.
REQ-010 Port: comm_cnt  output  16  commutation step count, wraps at 16'hFFFF -> 0.
REQ-011 Port: stall  output  1  stall flag.

Function
REQ-012 A 3-bit step index idx (0..5) SHALL drive {hallGrn,hallYlw,hallBlu}: 0=001, 1=011, 2=010, 3=110, 4=100, 5=101.
REQ-013 Expected drive {Grn,Ylw,Blu} per idx SHALL be: 0={00,01,10}, 1={01,00,10}, 2={01,10,00}, 3={00,10,01}, 4={10,00,01}, 5={10,01,00}.
REQ-014 On a cycle with PWM_synch=1 and sel matching the expected drive for the current idx, speed SHALL become min(speed + duty[10:4], 16'hFFFF).
REQ-015 On a cycle with PWM_synch=1 and all three sel = 11 (brake), speed SHALL become speed - (speed>>4).
REQ-016 On a cycle with PWM_synch=1 and any other sel combination, speed SHALL become speed - (speed>>8) (friction).
REQ-017 With PWM_synch=0, speed SHALL hold.
REQ-018 A 20-bit accumulator pos SHALL add the current (pre-update) speed every cycle.
REQ-019 When pos + speed >= COMM_THRESH, pos SHALL become pos + speed - COMM_THRESH, idx SHALL advance (5 -> 0 wraps), and comm_cnt SHALL increment, all in the same cycle.
REQ-020 At most one commutation SHALL occur per cycle.
REQ-021 Hall outputs SHALL reflect the new idx one cycle after the advancing edge.
REQ-022 On simultaneous speed update and commutation, the speed rule SHALL use the pre-advance idx; pos SHALL use the pre-update speed.
REQ-023 duty[10:4]=0 with matching drive SHALL leave speed unchanged.

Reset
REQ-024 While rst_n=0: idx=0 (hall outputs 001), speed=0, pos=0, comm_cnt=0, stall=0, stall counter=0.
REQ-025 Reset asserted mid-operation SHALL immediately force all REQ-024 values, regardless of clk.
REQ-026 The first update SHALL occur on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 Macro BLDC_STALL_DET_EN: when defined, a counter SHALL increment on each PWM_synch while post-update speed==0.
REQ-028 With the macro defined, the counter SHALL clear on any nonzero speed and SHALL saturate at STALL_LIMIT.
REQ-029 With the macro defined, stall SHALL be 1 while the counter equals STALL_LIMIT.
REQ-030 When BLDC_STALL_DET_EN is not defined, stall SHALL be constant 0 and no stall counter SHALL exist.

Verification
REQ-031 Reset scenario: assert rst_n=0 mid-run -> hall=001, speed=0, comm_cnt=0, stall=0 without a clk edge.
REQ-032 Acceleration scenario: idx=0, sel={00,01,10}, duty=11'h400, one PWM_synch -> speed=16'h0040.
REQ-033 Brake and friction scenario: speed=16'h1000, all sel=11, PWM_synch -> speed=16'h0F00; sel all 00, PWM_synch -> speed=16'h0EF1.
REQ-034 Commutation scenario: speed=16'h8000, COMM_THRESH=20'h40000, from pos=0 -> idx advances on the 8th cycle; hall=011 and comm_cnt=1 on the following cycle.
REQ-035 Saturation scenario: speed=16'hFFF0, matching drive, duty=11'h7FF, PWM_synch -> speed=16'hFFFF.
REQ-036 Stall scenario (macro defined, STALL_LIMIT=3): speed=0 and 3 PWM_synch strobes -> stall=1; one accelerating strobe -> stall=0.

Source files
------------

// File: rtl/bldc_hall_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bldc_hall_model                                                |
// | Brief   : BLDC rotor/hall emulator; speed integrates into a position     |
// |           accumulator that steps six-state hall outputs. Optional stall  |
// |           detection when BLDC_STALL_DET_EN is defined.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bldc_hall_model #(
  parameter logic [19:0] COMM_THRESH = 20'h40000,
  parameter logic [9:0]  STALL_LIMIT = 10'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  selGrn,
  input  logic [1:0]  selYlw,
  input  logic [1:0]  selBlu,
  input  logic [10:0] duty,
  input  logic        PWM_synch,
  output logic        hallGrn,
  output logic        hallYlw,
  output logic        hallBlu,
  output logic [15:0] speed,
  output logic [15:0] comm_cnt,
  output logic        stall
);

  localparam logic [2:0] c_IDX_LAST = 3'd5;
  localparam logic [5:0] c_BRAKE    = 6'b11_11_11;

  logic [2:0]  r_idx;
  logic [2:0]  r_hall;
  logic [15:0] r_speed;
  logic [19:0] r_pos;
  logic [15:0] r_comm_cnt;

  logic [2:0]  w_idx_next;
  logic [2:0]  w_hall_next;
  logic [15:0] w_speed_next;
  logic [19:0] w_pos_next;
  logic [5:0]  w_exp_drive;
  logic [5:0]  w_sel;
  logic [16:0] w_accel;
  logic [20:0] w_pos_sum;
  logic        w_commutate;

  assign w_sel = {selGrn, selYlw, selBlu};

  always_comb begin
    w_exp_drive = 6'b00_01_10;
    case (r_idx)
      3'd0:    w_exp_drive = 6'b00_01_10;
      3'd1:    w_exp_drive = 6'b01_00_10;
      3'd2:    w_exp_drive = 6'b01_10_00;
      3'd3:    w_exp_drive = 6'b00_10_01;
      3'd4:    w_exp_drive = 6'b10_00_01;
      3'd5:    w_exp_drive = 6'b10_01_00;
      default: w_exp_drive = 6'b00_01_10;
    endcase
  end

  assign w_accel = {1'b0, r_speed} + {10'd0, duty[10:4]};

  always_comb begin
    w_speed_next = r_speed;
    if (PWM_synch) begin
      if (w_sel == w_exp_drive)
        w_speed_next = w_accel[16] ? 16'hFFFF : w_accel[15:0];
      else if (w_sel == c_BRAKE)
        w_speed_next = r_speed - (r_speed >> 4);
      else
        w_speed_next = r_speed - (r_speed >> 8);
    end
  end

  // pos stays below COMM_THRESH, so the post-commutation value always fits in 20 bits
  assign w_pos_sum   = {1'b0, r_pos} + {5'd0, r_speed};
  assign w_commutate = (w_pos_sum >= {1'b0, COMM_THRESH});
  assign w_pos_next  = w_commutate ? (w_pos_sum[19:0] - COMM_THRESH) : w_pos_sum[19:0];

  always_comb begin
    w_idx_next = r_idx;
    if (w_commutate)
      w_idx_next = (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
  end

  always_comb begin
    w_hall_next = 3'b001;
    case (w_idx_next)
      3'd0:    w_hall_next = 3'b001;
      3'd1:    w_hall_next = 3'b011;
      3'd2:    w_hall_next = 3'b010;
      3'd3:    w_hall_next = 3'b110;
      3'd4:    w_hall_next = 3'b100;
      3'd5:    w_hall_next = 3'b101;
      default: w_hall_next = 3'b001;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 3'd0;
      r_hall     <= 3'b001;
      r_speed    <= 16'd0;
      r_pos      <= 20'd0;
      r_comm_cnt <= 16'd0;
    end else begin
      r_idx   <= w_idx_next;
      r_hall  <= w_hall_next;
      r_speed <= w_speed_next;
      r_pos   <= w_pos_next;
      if (w_commutate)
        r_comm_cnt <= r_comm_cnt + 16'd1;
    end
  end

`ifdef BLDC_STALL_DET_EN
  logic [9:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= 10'd0;
    else if (w_speed_next != 16'd0)
      r_stall_cnt <= 10'd0;
    else if (PWM_synch && (r_stall_cnt != STALL_LIMIT))
      r_stall_cnt <= r_stall_cnt + 10'd1;
  end

  assign stall = (r_stall_cnt == STALL_LIMIT);
`else
  assign stall = 1'b0;
`endif

  assign {hallGrn, hallYlw, hallBlu} = r_hall;
  assign speed    = r_speed;
  assign comm_cnt = r_comm_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bldc_hall_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bldc_hall_model                                             |
// | Brief   : Self-checking bench for bldc_hall_model: vector table,         |
// |           directed corner sequences and random stimulus vs. a model.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bldc_hall_model;

  localparam int             THRESH    = 'h40000;
  localparam logic [9:0]     STALL_LIM = 10'd3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [10:0] duty;
  logic        PWM_synch;
  logic        hallGrn, hallYlw, hallBlu;
  logic [15:0] speed;
  logic [15:0] comm_cnt;
  logic        stall;

  bldc_hall_model #(
    .COMM_THRESH (20'h40000),
    .STALL_LIMIT (STALL_LIM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .selGrn    (selGrn),
    .selYlw    (selYlw),
    .selBlu    (selBlu),
    .duty      (duty),
    .PWM_synch (PWM_synch),
    .hallGrn   (hallGrn),
    .hallYlw   (hallYlw),
    .hallBlu   (hallBlu),
    .speed     (speed),
    .comm_cnt  (comm_cnt),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, plain integers
  int m_idx, m_speed, m_pos, m_comm, m_stall_cnt;
  int exp_drive [6] = '{6'b000110, 6'b010010, 6'b011000, 6'b001001, 6'b100001, 6'b100100};
  int hall_pat  [6] = '{1, 3, 2, 6, 4, 5};

  typedef struct {
    logic [5:0]  sel;
    logic [10:0] d;
    logic        p;
    logic [15:0] exp_speed;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hall_now();
    return int'({hallGrn, hallYlw, hallBlu});
  endfunction

  function automatic int model_stall();
`ifdef BLDC_STALL_DET_EN
    return (m_stall_cnt == int'(STALL_LIM)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_idx = 0; m_speed = 0; m_pos = 0; m_comm = 0; m_stall_cnt = 0;
  endtask

  task automatic model_step(input int s6, input int d, input bit p);
    int old_speed;
    old_speed = m_speed;
    if (p) begin
      if (s6 == exp_drive[m_idx]) begin
        m_speed = old_speed + d / 16;
        if (m_speed > 65535) m_speed = 65535;
      end else if (s6 == 63)
        m_speed = old_speed - old_speed / 16;
      else
        m_speed = old_speed - old_speed / 256;
    end
    if (m_speed != 0) m_stall_cnt = 0;
    else if (p && m_stall_cnt < int'(STALL_LIM)) m_stall_cnt++;
    m_pos = m_pos + old_speed;
    if (m_pos >= THRESH) begin
      m_pos  = m_pos - THRESH;
      m_idx  = (m_idx + 1) % 6;
      m_comm = (m_comm + 1) % 65536;
    end
  endtask

  task automatic check_model();
    check("hall",     hall_now(),      hall_pat[m_idx]);
    check("speed",    int'(speed),     m_speed);
    check("comm_cnt", int'(comm_cnt),  m_comm);
    check("stall",    int'(stall),     model_stall());
  endtask

  task automatic tick(input logic [5:0] s6, input logic [10:0] d, input logic p);
    {selGrn, selYlw, selBlu} = s6;
    duty      = d;
    PWM_synch = p;
    @(posedge clk);
    model_step(int'(s6), int'(d), p);
    #1;
    check_model();
  endtask

  // Asynchronous reset, checked before any clock edge can occur
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_hall",  hall_now(),     1);
    check("rst_speed", int'(speed),    0);
    check("rst_comm",  int'(comm_cnt), 0);
    check("rst_stall", int'(stall),    0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ramp_to(input int target);
    int inc;
    while (m_speed < target) begin
      inc = target - m_speed;
      if (inc > 127) inc = 127;
      tick(6'(exp_drive[m_idx]), 11'(inc * 16), 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_comm, first, n_pred, idx0, r;
    logic [5:0] s6;

    vecs[0] = '{6'b000110, 11'h400, 1'b1, 16'h0040};
    vecs[1] = '{6'b000110, 11'h00F, 1'b1, 16'h0040};
    vecs[2] = '{6'b000110, 11'h7FF, 1'b0, 16'h0040};
    vecs[3] = '{6'b000110, 11'h7FF, 1'b1, 16'h00BF};
    vecs[4] = '{6'b111111, 11'h7FF, 1'b1, 16'h00B4};
    vecs[5] = '{6'b000000, 11'h123, 1'b1, 16'h00B4};
    vecs[6] = '{6'b010010, 11'h7FF, 1'b1, 16'h00B4};
    vecs[7] = '{6'b111110, 11'h7FF, 1'b1, 16'h00B4};
    vecs[8] = '{6'b000110, 11'h100, 1'b1, 16'h00C4};

    rst_n = 1'b0; selGrn = 2'b00; selYlw = 2'b00; selBlu = 2'b00;
    duty = 11'd0; PWM_synch = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_hall",  hall_now(),     1);
    check("init_speed", int'(speed),    0);
    check("init_comm",  int'(comm_cnt), 0);
    check("init_stall", int'(stall),    0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].sel, vecs[i].d, vecs[i].p);
      check("vec_speed", int'(speed), int'(vecs[i].exp_speed));
    end

    do_reset();

    // Brake then friction from a known speed
    ramp_to('h1000);
    check("ramp_1000", int'(speed), 'h1000);
    tick(6'b111111, 11'h000, 1'b1);
    check("brake", int'(speed), 'h0F00);
    tick(6'b000000, 11'h000, 1'b1);
    check("friction", int'(speed), 'h0EF1);

    do_reset();
    ramp_to('hFFF0);
    check("ramp_fff0", int'(speed), 'hFFF0);
    tick(6'(exp_drive[m_idx]), 11'h7FF, 1'b1);
    check("saturate", int'(speed), 'hFFFF);

    // Commutation latency at constant speed
    start_comm = m_comm;
    idx0       = m_idx;
    n_pred     = (THRESH - m_pos + m_speed - 1) / m_speed;
    first      = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      tick(6'b000000, 11'h000, 1'b0);
      if (int'(comm_cnt) != start_comm) first = i;
    end
    check("comm_latency", first, n_pred);
    check("comm_hall", hall_now(), hall_pat[(idx0 + 1) % 6]);
    check("comm_step", int'(comm_cnt), (start_comm + 1) % 65536);

    // Stall detection at zero speed
    do_reset();
    tick(6'b000000, 11'h000, 1'b1);
    tick(6'b000000, 11'h000, 1'b1);
    check("stall_early", int'(stall), 0);
    tick(6'b000000, 11'h000, 1'b1);
`ifdef BLDC_STALL_DET_EN
    check("stall_set", int'(stall), 1);
`else
    check("stall_off", int'(stall), 0);
`endif
    tick(6'(exp_drive[m_idx]), 11'h7FF, 1'b1);
    check("stall_clear", int'(stall), 0);

    // Random traffic, with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      r = int'($urandom_range(0, 9));
      if (r < 5)      s6 = 6'(exp_drive[m_idx]);
      else if (r < 7) s6 = 6'b111111;
      else            s6 = 6'($urandom_range(0, 63));
      tick(s6, 11'($urandom_range(0, 2047)), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
